bus_dma_master: RTL

BUS_DMA_MASTER -- requirements
Module: bus_dma_master

---
 rtl/bus_dma_master.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bus_dma_master.sv
// Single-channel word-copy DMA master: reads one 32-bit word, writes it, and repeats for word_cnt words.
// Optional abort input is enabled with the BUS_DMA_ABORT_EN macro.
module bus_dma_master #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_cnt,
`ifdef BUS_DMA_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             rd_req,
  output logic [3:0]       rd_be,
  output logic [31:0]      rd_addr,
  input  logic             rd_gnt,
  input  logic [31:0]      rd_data,
  output logic             wr_req,
  output logic [3:0]       wr_be,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  input  logic             wr_gnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abort_pend_q, abort_pend_d;
  logic             abort_in;

`ifdef BUS_DMA_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    abort_pend_d = abort_pend_q;
    rd_req       = 1'b0;
    rd_be        = 4'h0;
    rd_addr      = 32'h0;
    wr_req       = 1'b0;
    wr_be        = 4'h0;
    wr_addr      = 32'h0;
    wr_data      = 32'h0;

    case (state_q)
      S_IDLE: begin
        // busy_q still covers the done cycle, so a start there is dropped
        if (start && !busy_q) begin
          src_d        = {src_addr[31:2], 2'b00};
          dst_d        = {dst_addr[31:2], 2'b00};
          cnt_d        = word_cnt;
          abort_pend_d = 1'b0;
          state_d      = (word_cnt == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (abort_in) begin
          state_d = S_DONE;
        end else begin
          rd_req  = 1'b1;
          rd_be   = 4'hF;
          rd_addr = src_q;
          if (rd_gnt) state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        data_d  = rd_data;
        state_d = S_WR_REQ;
        if (abort_in) abort_pend_d = 1'b1;
      end
      S_WR_REQ: begin
        wr_req  = 1'b1;
        wr_be   = 4'hF;
        wr_addr = dst_q;
        wr_data = data_q;
        if (abort_in) abort_pend_d = 1'b1;
        if (wr_gnt) begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          cnt_d = cnt_q - CNT_ONE;
          if ((cnt_q == CNT_ONE) || abort_pend_d) begin
            state_d      = S_DONE;
            abort_pend_d = 1'b0;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_q == S_DONE);
    busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
